hello_marquee_display: RTL and testbench

//  Downstream consumer of the 3-bit state/character register in the HELLO FSM datapath.

---
 rtl/hello_marquee_display.sv | 126 ++++++++++++
 tb/tb_hello_marquee_display.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hello_marquee_display.sv
`default_nettype none
`timescale 1ns/1ps
//==============================================================================
// Module   : hello_marquee_display
// Desc     : Ring-buffered HELLO character store driving seven-segment digits,
//            either static or scrolling as a marquee at a prescaled rate.
// Revision : 1.0 - initial release
//==============================================================================
module hello_marquee_display #(
    parameter int TICK_DIV = 25_000_000,
    parameter int DEPTH    = 8,
    parameter int DIGITS   = 6
) (
    input  logic                         Clk,
    input  logic                         Clr,
    input  logic [2:0]                   Code,
    input  logic                         Load,
    input  logic                         Run,
    output logic [7*DIGITS-1:0]          Seg,
    output logic                         Step,
    output logic [$clog2(DEPTH+1)-1:0]   Count,
    output logic                         Full
);

    localparam int c_PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W  = $clog2(DEPTH+1);
    localparam int c_TICK_W = $clog2(TICK_DIV);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_FILL   = 2'd1;
    localparam logic [1:0] c_SCROLL = 2'd2;

    localparam logic [2:0] c_BLANK = 3'b100;

    logic [1:0]            r_state;
    logic [2:0]            r_ring [DEPTH];
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_ofs;
    logic [c_TICK_W-1:0]   r_presc;
    logic [c_CNT_W-1:0]    r_count;
    logic                  r_step;
    logic [7*DIGITS-1:0]   r_seg;

    logic                  w_full;
    logic                  w_load_ok;
    logic [7*DIGITS-1:0]   w_seg;

    function automatic logic [6:0] f_decode(input logic [2:0] code);
        case (code)
            3'b000:  f_decode = 7'b0001001;
            3'b001:  f_decode = 7'b0000110;
            3'b010:  f_decode = 7'b1000111;
            3'b011:  f_decode = 7'b1000000;
            default: f_decode = 7'b1111111;
        endcase
    endfunction

    assign w_full    = (r_count == c_CNT_W'(DEPTH));
    assign w_load_ok = Load && !w_full && (r_state != c_SCROLL);

    // ofs < DEPTH and k < DEPTH, so one conditional subtract gives the modulo
    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        logic [c_PTR_W:0]   w_sum;
        logic [c_PTR_W-1:0] w_idx;
        assign w_sum = {1'b0, r_ofs} + (c_PTR_W+1)'(k);
        assign w_idx = (w_sum >= (c_PTR_W+1)'(DEPTH)) ?
                       c_PTR_W'(w_sum - (c_PTR_W+1)'(DEPTH)) : w_sum[c_PTR_W-1:0];
        assign w_seg[7*(DIGITS-k)-1 -: 7] = f_decode(r_ring[w_idx]);
    end

    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            r_state  <= c_IDLE;
            for (int i = 0; i < DEPTH; i++) r_ring[i] <= c_BLANK;
            r_wr_ptr <= '0;
            r_ofs    <= '0;
            r_presc  <= '0;
            r_count  <= '0;
            r_step   <= 1'b0;
            r_seg    <= '1;
        end else begin
            r_step <= 1'b0;
            r_seg  <= w_seg;

            if (w_load_ok) begin
                r_ring[r_wr_ptr] <= Code;
                r_wr_ptr         <= r_wr_ptr + c_PTR_W'(1);
                r_count          <= r_count + c_CNT_W'(1);
            end

            case (r_state)
                c_IDLE: begin
                    r_presc <= '0;
                    if (Load) r_state <= c_FILL;
                end
                c_FILL: begin
                    r_presc <= '0;
                    if (Run && (r_count != '0)) r_state <= c_SCROLL;
                end
                c_SCROLL: begin
                    if (!Run) begin
                        r_state <= c_FILL;
                        r_presc <= '0;
                    end else if (r_presc == c_TICK_W'(TICK_DIV-1)) begin
                        r_presc <= '0;
                        r_step  <= 1'b1;
                        r_ofs   <= (r_ofs == c_PTR_W'(DEPTH-1)) ? '0 : r_ofs + c_PTR_W'(1);
                    end else begin
                        r_presc <= r_presc + c_TICK_W'(1);
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                    r_presc <= '0;
                end
            endcase
        end
    end

    assign Seg   = r_seg;
    assign Step  = r_step;
    assign Count = r_count;
    assign Full  = w_full;

endmodule
`default_nettype wire

// File: tb/tb_hello_marquee_display.sv
`default_nettype none
`timescale 1ns/1ps
//==============================================================================
// Module   : tb_hello_marquee_display
// Desc     : Directed plus randomized bench for hello_marquee_display against a
//            behavioural model of the marquee.
// Revision : 1.0 - initial release
//==============================================================================
module tb_hello_marquee_display;

    localparam int TICK = 4;
    localparam int DEP  = 8;
    localparam int DIG  = 6;

    localparam logic [6:0] SH = 7'b0001001;
    localparam logic [6:0] SE = 7'b0000110;
    localparam logic [6:0] SL = 7'b1000111;
    localparam logic [6:0] SO = 7'b1000000;
    localparam logic [6:0] SB = 7'b1111111;

    localparam logic [41:0] W_HELLO = {SH, SE, SL, SL, SO, SB};
    localparam logic [41:0] W_ELLO  = {SE, SL, SL, SO, SB, SB};
    localparam logic [41:0] W_LO    = {SL, SO, SB, SB, SB, SH};
    localparam logic [41:0] W_HELLOH = {SH, SE, SL, SL, SO, SH};

    logic        Clk = 1'b0;
    logic        Clr;
    logic [2:0]  Code;
    logic        Load;
    logic        Run;
    logic [41:0] Seg;
    logic        Step;
    logic [3:0]  Count;
    logic        Full;

    int checks = 0;
    int errors = 0;

    // Behavioural model: entries are appended at index Count, scrolling is
    // tracked as elapsed cycles since SCROLL entry.
    int          m_ring [DEP];
    int          m_cnt;
    int          m_ofs;
    int          m_mode;    // 0 idle, 1 fill, 2 scroll
    int          m_since;
    logic [41:0] m_seg;
    logic        m_step;

    always #5 Clk = ~Clk;

    hello_marquee_display #(
        .TICK_DIV (TICK),
        .DEPTH    (DEP),
        .DIGITS   (DIG)
    ) dut (
        .Clk   (Clk),
        .Clr   (Clr),
        .Code  (Code),
        .Load  (Load),
        .Run   (Run),
        .Seg   (Seg),
        .Step  (Step),
        .Count (Count),
        .Full  (Full)
    );

    function automatic logic [6:0] dec(int c);
        if (c == 0) return SH;
        if (c == 1) return SE;
        if (c == 2) return SL;
        if (c == 3) return SO;
        return SB;
    endfunction

    function automatic logic [41:0] render();
        logic [41:0] s;
        s = '1;
        for (int k = 0; k < DIG; k++)
            s[41-7*k -: 7] = dec(m_ring[(m_ofs + k) % DEP]);
        return s;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEP; i++) m_ring[i] = 4;
        m_cnt   = 0;
        m_ofs   = 0;
        m_mode  = 0;
        m_since = 0;
        m_seg   = '1;
        m_step  = 1'b0;
    endtask

    task automatic model_edge(bit ld, int cd, bit rn);
        logic [41:0] nseg;
        int          old_cnt;
        nseg    = render();
        old_cnt = m_cnt;
        m_step  = 1'b0;
        if (ld && m_mode != 2 && m_cnt < DEP) begin
            m_ring[m_cnt] = cd;
            m_cnt++;
        end
        if (m_mode == 0) begin
            if (ld) m_mode = 1;
        end else if (m_mode == 1) begin
            if (rn && old_cnt > 0) begin
                m_mode  = 2;
                m_since = 0;
            end
        end else begin
            if (!rn) m_mode = 1;
            else begin
                m_since++;
                if (m_since % TICK == 0) begin
                    m_ofs  = (m_ofs + 1) % DEP;
                    m_step = 1'b1;
                end
            end
        end
        m_seg = nseg;
    endtask

    task automatic check(string tag, logic [41:0] got, logic [41:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_outputs();
        check("seg",   Seg, m_seg);
        check("step",  {41'd0, Step}, {41'd0, m_step});
        check("count", {38'd0, Count}, 42'(m_cnt));
        check("full",  {41'd0, Full}, {41'd0, (m_cnt == DEP)});
    endtask

    task automatic cycle(bit ld, int cd, bit rn);
        Load = ld;
        Code = cd[2:0];
        Run  = rn;
        @(posedge Clk);
        model_edge(ld, cd, rn);
        @(negedge Clk);
        check_outputs();
    endtask

    // Called at a falling edge; asserts Clr between clock edges.
    task automatic pulse_clr();
        Load = 1'b0;
        Run  = 1'b0;
        #2 Clr = 1'b1;
        #1;
        model_reset();
        check_outputs();
        @(posedge Clk);
        @(negedge Clk);
        Clr = 1'b0;
        check_outputs();
    endtask

    initial begin
        Clr  = 1'b1;
        Load = 1'b0;
        Run  = 1'b0;
        Code = 3'd0;
        model_reset();
        @(negedge Clk);
        @(negedge Clk);
        Clr = 1'b0;
        check_outputs();
        check("reset_seg", Seg, '1);

        // HELLO load, static display
        cycle(1, 0, 0);
        cycle(1, 1, 0);
        cycle(1, 2, 0);
        cycle(1, 2, 0);
        cycle(1, 3, 0);
        cycle(0, 0, 0);
        check("t2_count", {38'd0, Count}, 42'd5);
        check("t2_seg", Seg, W_HELLO);

        // scroll: first step four cycles after entry, wrap after eight steps
        cycle(0, 0, 1);
        repeat (3) cycle(0, 0, 1);
        cycle(0, 0, 1);
        check("t3_step1", {41'd0, Step}, 42'd1);
        cycle(0, 0, 1);
        check("t3_seg1", Seg, W_ELLO);
        repeat (28) cycle(0, 0, 1);
        check("t3_wrap", Seg, W_HELLO);

        // three more steps with loads attempted while scrolling, then freeze
        for (int i = 0; i < 11; i++) cycle(i % 2 == 0, int'($urandom_range(0, 7)), 1);
        check("t5_count", {38'd0, Count}, 42'd5);
        cycle(0, 0, 0);
        check("t5_frozen", Seg, W_LO);
        repeat (5) cycle(0, 0, 0);
        check("t5_still", Seg, W_LO);
        cycle(0, 0, 1);
        repeat (3) cycle(0, 0, 1);
        cycle(0, 0, 1);
        check("t5_restep", {41'd0, Step}, 42'd1);

        // reset mid-scroll, then quiet period
        repeat (6) cycle(0, 0, 1);
        pulse_clr();
        repeat (20) cycle(0, 0, 0);
        check("t1_count", {38'd0, Count}, 42'd0);

        // load and run together in FILL
        repeat (4) cycle(1, int'($urandom_range(0, 7)), 0);
        cycle(1, int'($urandom_range(0, 7)), 1);
        check("t6_count", {38'd0, Count}, 42'd5);
        repeat (3) cycle(0, 0, 1);
        cycle(0, 0, 1);
        check("t6_step", {41'd0, Step}, 42'd1);

        // fill to capacity; ninth load must not overwrite
        pulse_clr();
        cycle(1, 0, 0);
        cycle(1, 1, 0);
        cycle(1, 2, 0);
        cycle(1, 2, 0);
        cycle(1, 3, 0);
        cycle(1, 0, 0);
        cycle(1, 1, 0);
        cycle(1, 2, 0);
        check("t4_full", {41'd0, Full}, 42'd1);
        cycle(1, 3, 0);
        check("t4_count", {38'd0, Count}, 42'd8);
        cycle(0, 0, 0);
        check("t4_seg", Seg, W_HELLOH);

        // randomized traffic, including Load+Run in IDLE and occasional reset
        repeat (600) begin
            if ($urandom_range(0, 99) < 2) pulse_clr();
            else cycle($urandom_range(0, 99) < 30, int'($urandom_range(0, 7)),
                       $urandom_range(0, 99) < 70);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
